// File: rtl/tdm_demux_16ch.sv
// tdm_demux_16ch: 1:16 TDM deserializer with slot tracking and malformed-frame flagging.
// Optional parity beat per frame when PARITY_CHECK_EN is defined.
module tdm_demux_16ch #(
  parameter int NUM_CH = 16,
  parameter int SEL_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic              in_bit,
  input  logic              frame_start,
  output logic [SEL_W-1:0]  sel,
  output logic [NUM_CH-1:0] out,
  output logic              out_valid,
  output logic              frame_err,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, PARITY} state_t;
  state_t state, state_n;
  logic [SEL_W-1:0] sel_n;
  logic [NUM_CH-1:0] shadow, shadow_n, out_n;
  logic out_valid_n, frame_err_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sel       <= '0;
      shadow    <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      sel       <= sel_n;
      shadow    <= shadow_n;
      out       <= out_n;
      out_valid <= out_valid_n;
      frame_err <= frame_err_n;
    end
  end
  always_comb begin
    state_n     = state;
    sel_n       = sel;
    shadow_n    = shadow;
    out_n       = out;
    out_valid_n = 1'b0;
    frame_err_n = 1'b0;
    if (in_valid) begin
      if (frame_start) begin
        // Any frame_start outside IDLE aborts the partial frame and restarts at slot 0.
        frame_err_n = (state != IDLE);
        shadow_n[0] = in_bit;
        sel_n       = SEL_W'(1);
        state_n     = COLLECT;
      end else if (state == COLLECT) begin
        shadow_n[sel] = in_bit;
        sel_n         = sel + 1'b1;
        if (sel == SEL_W'(NUM_CH - 1)) begin
`ifdef PARITY_CHECK_EN
          state_n = PARITY;
`else
          out_n       = {in_bit, shadow[NUM_CH-2:0]};
          out_valid_n = 1'b1;
          state_n     = IDLE;
`endif
        end
      end
`ifdef PARITY_CHECK_EN
      else if (state == PARITY) begin
        out_valid_n = ~^{shadow, in_bit};
        frame_err_n = ^{shadow, in_bit};
        out_n       = out_valid_n ? shadow : out;
        state_n     = IDLE;
      end
`endif
    end
  end
  assign busy = (state != IDLE);
endmodule

// File: tb/tb_tdm_demux_16ch.sv
// tb_tdm_demux_16ch: randomized and directed bench against a queue-based frame model.
module tb_tdm_demux_16ch;
`ifdef PARITY_CHECK_EN
  localparam int FLEN = 17;
`else
  localparam int FLEN = 16;
`endif
  logic clk = 0, rst = 0, in_valid = 0, in_bit = 0, frame_start = 0;
  logic [3:0] sel;
  logic [15:0] out;
  logic out_valid, frame_err, busy;
  int total = 0, bad = 0;
  bit q[$];
  bit active = 0;
  logic [15:0] exp_out = 0;
  bit exp_ov = 0, exp_fe = 0;

  tdm_demux_16ch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
    .frame_start(frame_start), .sel(sel), .out(out),
    .out_valid(out_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model(input bit r, input bit v, input bit fs, input bit b);
    logic [15:0] w;
    bit p;
    exp_ov = 0;
    exp_fe = 0;
    if (r) begin
      q.delete();
      active = 0;
      exp_out = 0;
    end else if (v && fs) begin
      exp_fe = active;
      q.delete();
      q.push_back(b);
      active = 1;
    end else if (v && active) begin
      q.push_back(b);
      if (q.size() == FLEN) begin
        p = 0;
        for (int i = 0; i < FLEN; i++) p ^= q[i];
        for (int i = 0; i < 16; i++) w[i] = q[i];
        if (FLEN == 16 || !p) begin
          exp_out = w;
          exp_ov = 1;
        end else exp_fe = 1;
        q.delete();
        active = 0;
      end
    end
  endtask

  task automatic step(input bit r, input bit v, input bit fs, input bit b);
    rst = r; in_valid = v; frame_start = fs; in_bit = b;
    @(posedge clk);
    model(r, v, fs, b);
    #1;
    chk("out", out, exp_out);
    chk("out_valid", 16'(out_valid), 16'(exp_ov));
    chk("frame_err", 16'(frame_err), 16'(exp_fe));
    chk("sel", 16'(sel), active ? 16'(q.size() % 16) : 16'd0);
    chk("busy", 16'(busy), 16'(active));
    chk("excl", 16'(out_valid & frame_err), 16'd0);
  endtask

  task automatic send_frame(input logic [15:0] w, input int gmax, input bit perr);
    for (int k = 0; k < 16; k++) begin
      for (int g = $urandom_range(gmax, 0); g > 0; g--) step(0, 0, $urandom_range(1, 0), $urandom_range(1, 0));
      step(0, 1, k == 0, w[k]);
    end
    if (FLEN == 17) step(0, 1, 0, (^w) ^ perr);
  endtask

  initial begin
    step(1, $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0));
    step(1, $urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0));
    send_frame(16'hA5C3, 0, 0);
    step(0, 0, 0, 0);
    send_frame(16'hA5C3, 3, 0);
    step(0, 0, 0, 0);
    for (int k = 0; k < 7; k++) step(0, 1, k == 0, k[0]);
    send_frame(16'h1234, 0, 0);
    send_frame(16'hFFFF, 0, 0);
    send_frame(16'h0001, 0, 0);
    step(0, 0, 0, 0);
    send_frame(16'h0003, 0, 0);
    send_frame(16'h0003, 0, 1);
    for (int k = 0; k < 9; k++) step(0, 1, k == 0, 1);
    step(1, 1, 0, 1);
    step(0, 1, 0, 1);
    send_frame(16'h8001, 1, 0);
    for (int n = 0; n < 3000; n++)
      step($urandom_range(199, 0) == 0, $urandom_range(3, 0) != 0,
           $urandom_range(24, 0) == 0, $urandom_range(1, 0));
    for (int n = 0; n < 20; n++) send_frame(16'($urandom), 2, $urandom_range(3, 0) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
